// File: rtl/mux_nx1_stream.sv
// Registered N-to-1 valid/ready stream multiplexer with two selection modes:
// explicit select, or round-robin over the requesting channels.
module mux_nx1_stream #(
  parameter int unsigned LEN    = 8,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rr_mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_IN-1:0]     in_valid,
  input  logic [NUM_IN*LEN-1:0] in_data,
  output logic [NUM_IN-1:0]     in_ready,
  output logic                  out_valid,
  output logic [LEN-1:0]        out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic             load_en;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [LEN-1:0]   gnt_data;
  logic             xfer;

  assign load_en = !out_valid || out_ready;
  // Nothing is accepted while reset is high, so in_ready stays low in that cycle.
  assign xfer    = load_en && gnt_valid && !reset;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!rr_mode) begin
      // Out-of-range sel values match no channel and therefore never grant.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Rotating priority: channels at or above rr_ptr first, then the wrapped ones below it.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!gnt_valid && in_valid[i] && SEL_W'(i) >= rr_ptr) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!gnt_valid && in_valid[i] && SEL_W'(i) < rr_ptr) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data    = in_data[i*LEN +: LEN];
        in_ready[i] = xfer;
      end
    end
  end

  assign ptr_next = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_src   <= gnt_idx;
      if (rr_mode) begin
        rr_ptr <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
